// File: rtl/dmem_ctrl.sv
// Data-memory access controller: turns single-cycle core load/store requests into
// a request/ack bus transaction, stalling the core until the access completes.
module dmem_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        stall,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic [1:0]  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [31:0] rdata_q, rdata_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        bus_req_q, bus_req_d;
  logic        stall_raw;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    rdata_d   = rdata_q;
    cnt_d     = cnt_q;
    err_d     = 1'b0;
    stall_raw = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (mem_ren || mem_wen) begin
          stall_raw = 1'b1;
          addr_d    = dmem_addr;
          wdata_d   = dmem_wdata;
          we_d      = mem_wen;
          cnt_d     = 8'd0;
          if (dmem_addr[1:0] != 2'b00) begin
            err_d   = 1'b1;
            rdata_d = 32'd0;
            state_d = ST_DONE;
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        stall_raw = 1'b1;
        // An ack in the timeout cycle still wins: it is tested first.
        if (bus_ack) begin
          if (!we_q) rdata_d = bus_rdata;
          state_d = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          rdata_d = 32'd0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    bus_req_d = (state_d == ST_REQ);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      we_q      <= 1'b0;
      rdata_q   <= 32'd0;
      cnt_q     <= 8'd0;
      err_q     <= 1'b0;
      bus_req_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      rdata_q   <= rdata_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      bus_req_q <= bus_req_d;
    end
  end

  assign stall      = stall_raw & ~rst;
  assign dmem_rdata = rdata_q;
  assign bus_req    = bus_req_q;
  assign bus_we     = we_q;
  assign bus_addr   = addr_q;
  assign bus_wdata  = wdata_q;
  assign err        = err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: directed scenarios plus random accesses
// scored against a transaction-level model of stall/bus/err/read-data behaviour.
module tb_dmem_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_ren, mem_wen;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        stall, bus_req, bus_we, bus_ack, err;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] model_latch = 32'd0;

  always #5 clk = ~clk;

  dmem_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .mem_ren(mem_ren), .mem_wen(mem_wen),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .stall(stall),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .err(err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One core instruction: request held until stall drops; ack_at = REQ cycle that
  // sees bus_ack (1-based), 0 or beyond TO means the bus never answers.
  task automatic do_access(input string tag, input logic ren, input logic wen,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int ack_at, input logic [31:0] rdata);
    logic        misal;
    logic        ok;
    logic        exp_err;
    int          exp_req, exp_stall;
    logic [31:0] exp_latch;
    int          stall_n = 0, req_n = 0, err_n = 0, guard = 0;
    logic        bad_hold = 1'b0;

    misal = (addr[1:0] != 2'b00);
    ok    = !misal && ack_at >= 1 && ack_at <= TO;
    if (misal) begin
      exp_req = 0; exp_stall = 1; exp_err = 1'b1; exp_latch = 32'd0;
    end else if (ok) begin
      exp_req = ack_at; exp_stall = ack_at + 1; exp_err = 1'b0;
      exp_latch = wen ? model_latch : rdata;
    end else begin
      exp_req = TO; exp_stall = TO + 1; exp_err = 1'b1; exp_latch = 32'd0;
    end

    @(negedge clk);
    mem_ren = ren; mem_wen = wen; dmem_addr = addr; dmem_wdata = wdata; bus_ack = 1'b0;
    #1;
    check({tag, ":idle_hold"}, dmem_rdata, model_latch);
    while (stall === 1'b1 && guard < 64) begin
      stall_n++;
      if (err) err_n++;
      if (bus_req) begin
        req_n++;
        if (bus_we !== wen || bus_addr !== addr || bus_wdata !== wdata) bad_hold = 1'b1;
        if (req_n == ack_at) begin
          bus_ack = 1'b1;
          bus_rdata = rdata;
        end
      end
      @(negedge clk);
      bus_ack = 1'b0;
      bus_rdata = $urandom;
      #1;
      guard++;
    end
    check({tag, ":bound"}, 32'(guard < 64), 32'd1);
    check({tag, ":stall_cycles"}, 32'(stall_n), 32'(exp_stall));
    check({tag, ":req_cycles"}, 32'(req_n), 32'(exp_req));
    check({tag, ":err_early"}, 32'(err_n), 32'd0);
    check({tag, ":bus_hold"}, {31'd0, bad_hold}, 32'd0);
    check({tag, ":done_err"}, {31'd0, err}, {31'd0, exp_err});
    check({tag, ":done_req"}, {31'd0, bus_req}, 32'd0);
    check({tag, ":done_rdata"}, dmem_rdata, exp_latch);
    model_latch = exp_latch;
    // A stray ack in DONE must not disturb the latch.
    if ($urandom_range(0, 1) == 1) begin
      bus_ack = 1'b1;
      bus_rdata = $urandom;
    end
  endtask

  initial begin
    rst = 1'b1; mem_ren = 1'b1; mem_wen = 1'b0; dmem_addr = 32'h0; dmem_wdata = 32'h0;
    bus_ack = 1'b0; bus_rdata = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    check("rst:stall", {31'd0, stall}, 32'd0);
    check("rst:bus_req", {31'd0, bus_req}, 32'd0);
    check("rst:err", {31'd0, err}, 32'd0);
    check("rst:rdata", dmem_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0; mem_ren = 1'b0;

    do_access("rd_ack1",   1'b1, 1'b0, 32'h100, 32'h0,        1, 32'hCAFEF00D);
    do_access("wr_ack3",   1'b0, 1'b1, 32'h204, 32'h12345678, 3, 32'hDEADBEEF);
    do_access("rd_misal",  1'b1, 1'b0, 32'h102, 32'h0,        1, 32'h11111111);
    do_access("rd_ok",     1'b1, 1'b0, 32'h40,  32'h0,        2, 32'h0BADF00D);
    do_access("rd_tmo",    1'b1, 1'b0, 32'h80,  32'h0,        0, 32'h22222222);
    do_access("rd_ack_at_tmo", 1'b1, 1'b0, 32'h84, 32'h0,    TO, 32'h5A5A5A5A);
    do_access("both_wr",   1'b1, 1'b1, 32'h300, 32'hA5A5A5A5, 1, 32'h33333333);
    do_access("b2b_rd",    1'b1, 1'b0, 32'h304, 32'h0,        1, 32'h44444444);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      logic        r, w;
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      r = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      if (!r && !w) r = 1'b1;
      do_access($sformatf("rnd%0d", i), r, w, a, $urandom, $urandom_range(0, TO + 2), $urandom);
    end

    do_access("pre_rst_rd", 1'b1, 1'b0, 32'h500, 32'h0, 1, 32'h77777777);
    @(negedge clk);
    mem_ren = 1'b0; mem_wen = 1'b0; bus_ack = 1'b0;
    #1;
    check("idle:rdata_hold", dmem_rdata, model_latch);
    check("idle:stall", {31'd0, stall}, 32'd0);

    // Reset on the second REQ cycle, then a late ack that must be ignored.
    @(negedge clk);
    mem_ren = 1'b1; dmem_addr = 32'h600;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_mid:req_before", {31'd0, bus_req}, 32'd1);
    rst = 1'b1;
    #1;
    check("rst_mid:stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    rst = 1'b0; mem_ren = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h99999999;
    #1;
    check("rst_mid:bus_req", {31'd0, bus_req}, 32'd0);
    check("rst_mid:err", {31'd0, err}, 32'd0);
    check("rst_mid:rdata", dmem_rdata, 32'd0);
    @(negedge clk);
    bus_ack = 1'b0;
    #1;
    check("rst_late_ack:rdata", dmem_rdata, 32'd0);
    check("rst_late_ack:err", {31'd0, err}, 32'd0);
    check("rst_late_ack:bus_req", {31'd0, bus_req}, 32'd0);
    check("rst_late_ack:stall", {31'd0, stall}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
